// File: rtl/video_mix_pkg.sv
// Shared types and colour helpers for the post-scandoubler output stage.
package video_mix_pkg;

  typedef enum logic [1:0] {
    SL_NONE = 2'b00,
    SL_25   = 2'b01,
    SL_50   = 2'b10,
    SL_75   = 2'b11
  } sl_level_t;

  // c_left holds the component left-justified in 8 bits with zero LSBs;
  // OR-ing in a copy shifted by the depth replicates the MSBs into the gap.
  function automatic logic [7:0] expand_c(input logic [7:0] c_left, input int unsigned bits);
    return c_left | (c_left >> bits);
  endfunction

  function automatic logic [7:0] darken(input logic [7:0] c, input sl_level_t level);
    logic [7:0] r;
    case (level)
      SL_25:   r = (c >> 1) + (c >> 2);
      SL_50:   r = c >> 1;
      SL_75:   r = c >> 2;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/video_mixer_pl_if.sv
// Video bundle between the scandoubler mux (master) and the mixer (slave).
interface video_mixer_pl_if #(
  parameter int COLOR_BITS = 8,
  parameter int CNT_W      = 12
);
  // No handshake: ce_pix qualifies each pixel, there is no backpressure, and
  // every output is a fixed 2-clock delay of the matching inputs.
  logic                  ce_pix;
  logic [1:0]            scanlines;
  logic                  field;
  logic                  mono;
  logic [COLOR_BITS-1:0] R, G, B;
  logic                  HSync, VSync;
  logic                  HBlank, VBlank;

  logic                  ce_pix_out;
  logic [7:0]            VGA_R, VGA_G, VGA_B;
  logic                  VGA_HS, VGA_VS, VGA_DE;
  logic [CNT_W-1:0]      hdisp, vdisp;

  modport master (
    output ce_pix, scanlines, field, mono, R, G, B, HSync, VSync, HBlank, VBlank,
    input  ce_pix_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, hdisp, vdisp
  );

  modport slave (
    input  ce_pix, scanlines, field, mono, R, G, B, HSync, VSync, HBlank, VBlank,
    output ce_pix_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, hdisp, vdisp
  );
endinterface

// File: rtl/video_timing_meter.sv
// Measures active pixels per line and active lines per frame from the stage-1 DE.
module video_timing_meter #(
  parameter int CNT_W = 12
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_ce,
  input  logic             i_de,
  input  logic             i_vs,
  output logic [CNT_W-1:0] o_hdisp,
  output logic [CNT_W-1:0] o_vdisp
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_de_d;
  logic             r_vs_d;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_hdisp;
  logic [CNT_W-1:0] r_vdisp;

  logic             w_de_fall;
  logic             w_vs_rise;
  logic [CNT_W-1:0] w_vcnt_next;

  always_comb begin
    w_de_fall   = r_de_d & ~i_de;
    w_vs_rise   = ~r_vs_d & i_vs;
    w_vcnt_next = r_vcnt;
    if (w_de_fall && (r_vcnt != CNT_MAX)) w_vcnt_next = r_vcnt + CNT_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_de_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_hdisp <= '0;
      r_vdisp <= '0;
    end else begin
      r_de_d <= i_de;
      r_vs_d <= i_vs;

      if (w_de_fall) begin
        r_hdisp <= r_hcnt;
        r_hcnt  <= '0;
      end else if (i_ce && i_de && (r_hcnt != CNT_MAX)) begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end

      // A line ending on the same clock as the VSync rise still belongs to the old frame.
      if (w_vs_rise) begin
        r_vdisp <= w_vcnt_next;
        r_vcnt  <= '0;
      end else begin
        r_vcnt <= w_vcnt_next;
      end
    end
  end

  assign o_hdisp = r_hdisp;
  assign o_vdisp = r_vdisp;

endmodule

// File: rtl/video_mixer_pl.sv
// Output stage: colour expansion/mono select (stage 1), scanline darkening (stage 2),
// clean DE generation and active-area measurement.
module video_mixer_pl
  import video_mix_pkg::*;
#(
  parameter int COLOR_BITS = 8,
  parameter int CNT_W      = 12
) (
  input logic             clk_sys,
  input logic             reset,
  video_mixer_pl_if.slave vif
);

  logic [7:0]       r1_r, r1_g, r1_b;
  logic             r1_hs, r1_vs, r1_de, r1_ce, r1_dark;
  sl_level_t        r1_sl;
  logic             r_phase;
  logic             r_hde_d;

  logic [7:0]       r2_r, r2_g, r2_b;
  logic             r2_hs, r2_vs, r2_de, r2_ce;

  logic [7:0]       w_r, w_g, w_b, w_mono;
  logic             w_hde, w_de_next, w_hs_fall, w_vs_fall;
  sl_level_t        w_level;
  logic [CNT_W-1:0] w_hdisp, w_vdisp;

  always_comb begin
    w_mono = 8'({vif.G, vif.R});
    if ((COLOR_BITS == 4) && vif.mono) begin
      w_r = w_mono;
      w_g = w_mono;
      w_b = w_mono;
    end else begin
      w_r = expand_c(8'(vif.R) << (8 - COLOR_BITS), COLOR_BITS);
      w_g = expand_c(8'(vif.G) << (8 - COLOR_BITS), COLOR_BITS);
      w_b = expand_c(8'(vif.B) << (8 - COLOR_BITS), COLOR_BITS);
    end
  end

  // DE opens only on an hde rise inside the vertical active area and closes on any
  // hde fall, so a VBlank change mid-line never cuts a line short or starts one.
  always_comb begin
    w_hde     = ~vif.HBlank;
    w_de_next = r1_de;
    if (w_hde && !r_hde_d && !vif.VBlank) w_de_next = 1'b1;
    else if (!w_hde && r_hde_d)           w_de_next = 1'b0;
    w_hs_fall = r1_hs & ~vif.HSync;
    w_vs_fall = r1_vs & ~vif.VSync;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r1_r    <= '0;
      r1_g    <= '0;
      r1_b    <= '0;
      r1_hs   <= 1'b0;
      r1_vs   <= 1'b0;
      r1_de   <= 1'b0;
      r1_ce   <= 1'b0;
      r1_dark <= 1'b0;
      r1_sl   <= SL_NONE;
      r_phase <= 1'b0;
      // Treat hde as already high so a reset released mid-line sees no rise.
      r_hde_d <= 1'b1;
    end else begin
      r1_r    <= w_r;
      r1_g    <= w_g;
      r1_b    <= w_b;
      r1_hs   <= vif.HSync;
      r1_vs   <= vif.VSync;
      r1_de   <= w_de_next;
      r1_ce   <= vif.ce_pix;
      r1_dark <= r_phase;
      r1_sl   <= sl_level_t'(vif.scanlines);
      r_hde_d <= w_hde;
      if (w_vs_fall)      r_phase <= vif.field;
      else if (w_hs_fall) r_phase <= ~r_phase;
    end
  end

  assign w_level = r1_dark ? r1_sl : SL_NONE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r2_r  <= '0;
      r2_g  <= '0;
      r2_b  <= '0;
      r2_hs <= 1'b0;
      r2_vs <= 1'b0;
      r2_de <= 1'b0;
      r2_ce <= 1'b0;
    end else begin
      r2_r  <= darken(r1_r, w_level);
      r2_g  <= darken(r1_g, w_level);
      r2_b  <= darken(r1_b, w_level);
      r2_hs <= r1_hs;
      r2_vs <= r1_vs;
      r2_de <= r1_de;
      r2_ce <= r1_ce;
    end
  end

  video_timing_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_ce    (r1_ce),
    .i_de    (r1_de),
    .i_vs    (r1_vs),
    .o_hdisp (w_hdisp),
    .o_vdisp (w_vdisp)
  );

  assign vif.VGA_R      = r2_r;
  assign vif.VGA_G      = r2_g;
  assign vif.VGA_B      = r2_b;
  assign vif.VGA_HS     = r2_hs;
  assign vif.VGA_VS     = r2_vs;
  assign vif.VGA_DE     = r2_de;
  assign vif.ce_pix_out = r2_ce;
  assign vif.hdisp      = w_hdisp;
  assign vif.vdisp      = w_vdisp;

endmodule

// File: tb/tb_video_mixer_pl.sv
// Directed bench for video_mixer_pl: a 4-bit and an 8-bit instance share timing stimulus.
module tb_video_mixer_pl;

  logic clk_sys = 1'b0;
  logic reset;

  always #5 clk_sys = ~clk_sys;

  video_mixer_pl_if #(.COLOR_BITS(4), .CNT_W(12)) vif4 ();
  video_mixer_pl_if #(.COLOR_BITS(8), .CNT_W(12)) vif8 ();

  video_mixer_pl #(.COLOR_BITS(4), .CNT_W(12)) dut4 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vif     (vif4.slave)
  );

  video_mixer_pl #(.COLOR_BITS(8), .CNT_W(12)) dut8 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vif     (vif8.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_sync(input logic hs, input logic vs, input logic hb, input logic vb);
    vif4.HSync = hs;  vif8.HSync = hs;
    vif4.VSync = vs;  vif8.VSync = vs;
    vif4.HBlank = hb; vif8.HBlank = hb;
    vif4.VBlank = vb; vif8.VBlank = vb;
  endtask

  task automatic set_ctl(input logic ce, input logic [1:0] sl, input logic fld, input logic mo);
    vif4.ce_pix = ce;     vif8.ce_pix = ce;
    vif4.scanlines = sl;  vif8.scanlines = sl;
    vif4.field = fld;     vif8.field = fld;
    vif4.mono = mo;       vif8.mono = mo;
  endtask

  task automatic set_rgb4(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    vif4.R = r; vif4.G = g; vif4.B = b;
  endtask

  task automatic set_rgb8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vif8.R = r; vif8.G = g; vif8.B = b;
  endtask

  task automatic hs_pulse(input logic with_vs);
    vif4.HSync = 1'b1; vif8.HSync = 1'b1;
    vif4.VSync = with_vs; vif8.VSync = with_vs;
    step(1);
    vif4.HSync = 1'b0; vif8.HSync = 1'b0;
    vif4.VSync = 1'b0; vif8.VSync = 1'b0;
    step(1);
  endtask

  // One line: 2 clocks HSync, 2 clocks back porch, n_act active, 2 clocks trailing blank.
  task automatic run_line(input int n_act, input logic vb, input logic vs_on, input logic ce_half);
    set_sync(1'b1, vs_on, 1'b1, vb);
    step(2);
    set_sync(1'b0, 1'b0, 1'b1, vb);
    step(2);
    vif4.HBlank = 1'b0; vif8.HBlank = 1'b0;
    for (int i = 0; i < n_act; i++) begin
      vif8.ce_pix = ce_half ? logic'(i % 2 == 0) : 1'b1;
      vif4.ce_pix = vif8.ce_pix;
      step(1);
      if (vb && i == n_act / 2) chk1("de_in_vblank", vif8.VGA_DE, 1'b0);
      if (!vb && i == 0)        chk1("de_rise_lat1", vif8.VGA_DE, 1'b0);
      if (!vb && i == 1)        chk1("de_rise_lat2", vif8.VGA_DE, 1'b1);
    end
    vif4.HBlank = 1'b1; vif8.HBlank = 1'b1;
    vif4.ce_pix = 1'b1; vif8.ce_pix = 1'b1;
    step(2);
  endtask

  initial begin
    reset = 1'b1;
    set_ctl(1'b1, 2'b00, 1'b0, 1'b0);
    set_sync(1'b1, 1'b1, 1'b1, 1'b1);
    set_rgb4(4'hA, 4'h5, 4'hF);
    set_rgb8(8'h12, 8'h34, 8'h56);
    step(3);

    chk8("rst_r4", vif4.VGA_R, 8'h00);
    chk8("rst_g8", vif8.VGA_G, 8'h00);
    chk1("rst_hs", vif4.VGA_HS, 1'b0);
    chk1("rst_vs", vif4.VGA_VS, 1'b0);
    chk1("rst_de", vif4.VGA_DE, 1'b0);
    chk1("rst_ce", vif4.ce_pix_out, 1'b0);
    chk12("rst_hdisp", vif4.hdisp, 12'd0);
    chk12("rst_vdisp", vif4.vdisp, 12'd0);

    // Expansion and 2-clock alignment
    reset = 1'b0;
    step(1);
    chk8("lat1_r4", vif4.VGA_R, 8'h00);
    chk1("lat1_hs", vif4.VGA_HS, 1'b0);
    step(1);
    chk8("exp_r4", vif4.VGA_R, 8'hAA);
    chk8("exp_g4", vif4.VGA_G, 8'h55);
    chk8("exp_b4", vif4.VGA_B, 8'hFF);
    chk1("lat2_hs", vif4.VGA_HS, 1'b1);
    chk1("lat2_vs", vif4.VGA_VS, 1'b1);
    chk1("lat2_ce", vif4.ce_pix_out, 1'b1);
    chk8("pass_r8", vif8.VGA_R, 8'h12);
    chk8("pass_g8", vif8.VGA_G, 8'h34);
    chk8("pass_b8", vif8.VGA_B, 8'h56);

    // Mono packing on the 4-bit instance; ignored on the 8-bit one
    set_sync(1'b0, 1'b0, 1'b1, 1'b1);
    set_ctl(1'b1, 2'b00, 1'b0, 1'b1);
    set_rgb4(4'hC, 4'h3, 4'h9);
    set_rgb8(8'h80, 8'h40, 8'h20);
    step(2);
    chk8("mono_r4", vif4.VGA_R, 8'h3C);
    chk8("mono_g4", vif4.VGA_G, 8'h3C);
    chk8("mono_b4", vif4.VGA_B, 8'h3C);
    chk8("mono_r8", vif8.VGA_R, 8'h80);
    chk8("mono_b8", vif8.VGA_B, 8'h20);
    chk1("hs_fall", vif4.VGA_HS, 1'b0);
    chk1("vs_fall", vif4.VGA_VS, 1'b0);

    // Scanlines: phase is 0 after VS fall with field=0
    set_ctl(1'b1, 2'b01, 1'b0, 1'b0);
    set_rgb4(4'hA, 4'h5, 4'hF);
    set_rgb8(8'hFF, 8'hFF, 8'hFF);
    step(2);
    chk8("sl25_even", vif8.VGA_R, 8'hFF);
    hs_pulse(1'b0);
    step(2);
    chk8("sl25_odd", vif8.VGA_R, 8'hBE);
    vif4.scanlines = 2'b10; vif8.scanlines = 2'b10;
    step(2);
    chk8("sl50_odd", vif8.VGA_G, 8'h7F);
    vif4.scanlines = 2'b11; vif8.scanlines = 2'b11;
    step(2);
    chk8("sl75_odd", vif8.VGA_B, 8'h3F);
    chk8("sl75_r4", vif4.VGA_R, 8'h2A);
    chk8("sl75_g4", vif4.VGA_G, 8'h15);

    // Field load on VS fall beats the simultaneous HS toggle
    vif4.field = 1'b1; vif8.field = 1'b1;
    hs_pulse(1'b1);
    step(2);
    chk8("fld1_line1", vif8.VGA_R, 8'h3F);
    hs_pulse(1'b0);
    step(2);
    chk8("fld1_line2", vif8.VGA_R, 8'hFF);
    vif4.field = 1'b0; vif8.field = 1'b0;
    hs_pulse(1'b1);
    step(2);
    chk8("fld0_line1", vif8.VGA_R, 8'hFF);
    hs_pulse(1'b0);
    step(2);
    chk8("fld0_line2", vif8.VGA_R, 8'h3F);

    // Active-area measurement
    set_ctl(1'b1, 2'b00, 1'b0, 1'b0);
    run_line(640, 1'b0, 1'b0, 1'b0);
    chk12("hdisp_640", vif8.hdisp, 12'd640);
    run_line(20, 1'b0, 1'b0, 1'b1);
    chk12("hdisp_ce_half", vif8.hdisp, 12'd10);
    run_line(8, 1'b1, 1'b1, 1'b0);
    chk12("vdisp_partial", vif8.vdisp, 12'd2);
    for (int l = 0; l < 480; l++) run_line(8, 1'b0, 1'b0, 1'b0);
    run_line(8, 1'b1, 1'b0, 1'b0);
    run_line(8, 1'b1, 1'b0, 1'b0);
    run_line(8, 1'b1, 1'b1, 1'b0);
    chk12("vdisp_480", vif8.vdisp, 12'd480);
    chk12("hdisp_8", vif4.hdisp, 12'd8);
    for (int l = 0; l < 3; l++) run_line(8, 1'b1, 1'b0, 1'b0);
    run_line(8, 1'b1, 1'b1, 1'b0);
    chk12("vdisp_empty", vif8.vdisp, 12'd0);
    for (int l = 0; l < 3; l++) run_line(8, 1'b0, 1'b0, 1'b0);
    run_line(8, 1'b1, 1'b1, 1'b0);
    chk12("vdisp_3", vif8.vdisp, 12'd3);

    // Reset mid-line
    set_rgb8(8'hFF, 8'hFF, 8'hFF);
    set_sync(1'b1, 1'b0, 1'b1, 1'b0);
    step(2);
    set_sync(1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    set_sync(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    chk1("mid_de_on", vif8.VGA_DE, 1'b1);
    set_sync(1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    chk1("vblank_mid_line", vif8.VGA_DE, 1'b1);
    set_sync(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1);
    chk1("mrst_de", vif8.VGA_DE, 1'b0);
    chk8("mrst_r8", vif8.VGA_R, 8'h00);
    chk1("mrst_ce", vif8.ce_pix_out, 1'b0);
    chk12("mrst_hdisp", vif8.hdisp, 12'd0);
    chk12("mrst_vdisp", vif8.vdisp, 12'd0);
    reset = 1'b0;
    step(3);
    chk1("post_rst_de_off", vif8.VGA_DE, 1'b0);
    chk1("post_rst_de_off4", vif4.VGA_DE, 1'b0);
    vif4.HBlank = 1'b1; vif8.HBlank = 1'b1;
    step(2);
    vif4.HBlank = 1'b0; vif8.HBlank = 1'b0;
    step(2);
    chk1("post_rst_de_on", vif8.VGA_DE, 1'b1);
    step(3);
    vif4.HBlank = 1'b1; vif8.HBlank = 1'b1;
    step(2);
    chk12("post_rst_hdisp", vif8.hdisp, 12'd5);
    chk1("post_rst_de_end", vif8.VGA_DE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
